// File: rtl/demux_dispatch_pkg.sv
// Shared constants, FSM state type and helpers for the 1:4 stream dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_dispatch_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int CH_IDX_WIDTH = 2;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // One-hot decode of a channel index into a per-channel valid vector
  function automatic logic [NUM_CHANNELS-1:0] ch_onehot(input logic [CH_IDX_WIDTH-1:0] idx);
    return NUM_CHANNELS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_channel_picker.sv
// Finds the first eligible channel starting at the round-robin pointer, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: none; found_o=0 tells the caller that nothing may be accepted.
module rr_channel_picker
  import demux_dispatch_pkg::*;
(
  input  logic [CH_IDX_WIDTH-1:0] ptr_i,
  input  logic [NUM_CHANNELS-1:0] mask_i,
  output logic [CH_IDX_WIDTH-1:0] target_o,
  output logic                    found_o
);

  // Scan offsets from farthest to nearest so the nearest eligible channel wins
  always_comb begin
    logic [CH_IDX_WIDTH-1:0] idx;
    idx      = '0;
    target_o = ptr_i;
    found_o  = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      idx = ptr_i + CH_IDX_WIDTH'(i);
      if (mask_i[idx]) begin
        target_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_stream_dispatcher.sv
// Dispatches one input stream word-by-word to 4 channels (round-robin or fixed select).
// Latency: 1 cycle from acceptance to channel valid; full throughput back-to-back.
// Backpressure: input ready only when a target exists and the holding register is empty or draining.
module demux_stream_dispatcher
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    Clock_In,
  input  logic                    Reset_N_In,
  input  logic                    Enable_In,
  input  logic                    Mode_In,
  input  logic [1:0]              Select_In,
  input  logic [3:0]              Channel_Mask_In,
  input  logic                    Data_Valid_In,
  input  logic [DATA_WIDTH-1:0]   Data_In,
  output logic                    Data_Ready_Out,
  output logic [DATA_WIDTH-1:0]   Data_Out,
  output logic [3:0]              Data_Valid_Out,
  input  logic [3:0]              Channel_Ready_In,
  output logic [1:0]              Select_Out,
  output logic                    Busy_Out,
  output logic [COUNT_WIDTH-1:0]  Dispatch_Count_Out
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CH_IDX_WIDTH-1:0] sel_q, sel_d;
  logic [CH_IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_CHANNELS-1:0] vld_q, vld_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [CH_IDX_WIDTH-1:0] rr_target;
  logic                    rr_found;
  logic [CH_IDX_WIDTH-1:0] target;
  logic                    target_found;
  logic                    holding;
  logic                    deliver;
  logic                    ready;
  logic                    accept;

  rr_channel_picker u_picker (
    .ptr_i    (ptr_q),
    .mask_i   (Channel_Mask_In),
    .target_o (rr_target),
    .found_o  (rr_found)
  );

  // Target for the next acceptance; the held word is never re-targeted
  assign target       = (Mode_In == MODE_FIXED) ? Select_In : rr_target;
  assign target_found = (Mode_In == MODE_FIXED) ? Channel_Mask_In[Select_In] : rr_found;

  assign holding = (state_q == HOLD);
  assign deliver = holding & Channel_Ready_In[sel_q];

  // Ready never looks at Data_Valid_In; the channel-ready path through deliver is deliberate
  assign ready  = Reset_N_In & Enable_In & target_found & (~holding | Channel_Ready_In[sel_q]);
  assign accept = Data_Valid_In & ready;

  // Next-state: deliver frees the register, accept refills it in the same cycle
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
    if (accept) begin
      state_d = HOLD;
      data_d  = Data_In;
      sel_d   = target;
      ptr_d   = target + CH_IDX_WIDTH'(1);
      vld_d   = ch_onehot(target);
    end else if (deliver) begin
      state_d = IDLE;
      vld_d   = '0;
    end
  end

  // FSM and holding register with registered channel valids
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Data_Ready_Out     = ready;
  assign Data_Out           = data_q;
  assign Data_Valid_Out     = vld_q;
  assign Select_Out         = sel_q;
  assign Busy_Out           = holding;
  assign Dispatch_Count_Out = cnt_q;

endmodule
